// File: rtl/if_id_buffer.sv
// if_id_buffer: two-entry in-order fetch-to-decode skid FIFO with flush, NOP fill and PC misalignment flag
module if_id_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic        i_if_valid,
  input  logic [31:0] i_if_pc,
  input  logic [31:0] i_if_instr,
  output logic        o_if_ready,
  output logic        o_id_valid,
  output logic [31:0] o_id_pc,
  output logic [31:0] o_id_instr,
  output logic        o_id_misalign,
  input  logic        i_id_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0]   pc_q    [DEPTH];
  logic [31:0]   instr_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop, we;
  assign o_if_ready    = count_q != CW'(DEPTH);
  assign o_id_valid    = count_q != '0;
  assign push          = i_if_valid && o_if_ready;
  assign pop           = o_id_valid && i_id_ready;
  assign we            = push && !i_flush;
  assign o_id_pc       = o_id_valid ? pc_q[head_q] : 32'h0000_0000;
  assign o_id_instr    = o_id_valid ? instr_q[head_q] : 32'h0000_0013;
  assign o_id_misalign = o_id_valid && (o_id_pc[1:0] != 2'b00);
  always_comb begin
    head_d  = i_flush ? '0 : head_q + AW'(pop);
    tail_d  = i_flush ? '0 : tail_q + AW'(push);
    count_d = i_flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge i_clk) begin
    if (we) begin
      pc_q[tail_q]    <= i_if_pc;
      instr_q[tail_q] <= i_if_instr;
    end
  end
endmodule
